// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
package alu_mc_pkg;

  // Opcode values carried on the 4-bit sel input. Values 9..15 are illegal.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SHF = 4'd2,
    OP_MUL = 4'd3,
    OP_DIV = 4'd4,
    OP_NOT = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_XOR = 4'd8
  } op_e;

  // Handshake FSM states of the top level.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  // True for the opcodes that go through the iterative multiply/divide unit.
  function automatic logic is_iterative(input logic [3:0] sel);
    return (sel == OP_MUL) || (sel == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide.
// One result bit per cycle; a start pulse loads the operands, and done
// pulses for one cycle once WIDTH steps have been taken.
module alu_mc_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // hi: product high half / partial remainder.
  // lo: multiplier shifting out / dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next;

  // Datapath for one step of either algorithm.
  // A zero divisor always "fits", which naturally yields an all-ones
  // quotient and leaves the dividend as the remainder.
  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    trial    = {hi_q, lo_q[WIDTH-1]};
    fits     = (trial >= {1'b0, opb_q});
    rem_next = WIDTH'(fits ? (trial - {1'b0, opb_q}) : trial);
  end

  // Load on start, then step once per cycle counting WIDTH-1 down to 0.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      hi_d     = '0;
      lo_d     = a;
      opb_d    = b;
      is_div_d = is_div;
      cnt_d    = CW'(WIDTH - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (is_div_q) begin
        hi_d = rem_next;
        lo_d = {lo_q[WIDTH-2:0], fits};
      end else begin
        hi_d = add_sum[WIDTH:1];
        lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // State registers; reset abandons any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops go IDLE->EXEC->DONE, multiply/divide go IDLE->CALC->DONE.
// out_valid is registered one cycle after DONE is entered, giving a
// latency of 2 (single-cycle) or WIDTH+2 (MUL/DIV) edges from accept.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             cout,
  output logic             zero,
  output logic             dz,
  output logic             ill
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
  logic             ill_q, ill_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] exec_out1;
  logic [WIDTH-1:0] exec_out2;
  logic             exec_cout;
  logic             exec_ill;

  assign in_ready = (state_q == IDLE) && !md_busy;
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_iterative(sel);

  alu_mc_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (sel == OP_DIV),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // Single-cycle operations computed from the captured operands.
  // The borrow of SUB is the sign bit of the (WIDTH+1)-bit difference.
  always_comb begin
    add_full  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    sub_full  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
    exec_out1 = '0;
    exec_out2 = '0;
    exec_cout = 1'b0;
    exec_ill  = 1'b0;
    case (sel_q)
      OP_ADD: {exec_cout, exec_out1} = add_full;
      OP_SUB: begin
        exec_out1 = sub_full[WIDTH-1:0];
        exec_cout = sub_full[WIDTH];
      end
      OP_SHF: begin
        exec_out1 = a_q << b_q[SHW-1:0];
        exec_out2 = a_q >> b_q[SHW-1:0];
      end
      OP_NOT: begin
        exec_out1 = ~a_q;
        exec_out2 = ~b_q;
      end
      OP_AND: exec_out1 = a_q & b_q;
      OP_OR:  exec_out1 = a_q | b_q;
      OP_XOR: exec_out1 = a_q ^ b_q;
      OP_MUL, OP_DIV: begin
      end
      default: exec_ill = 1'b1;
    endcase
  end

  // Handshake FSM, operand capture and result registers.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    sel_d       = sel_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    dz_d        = dz_q;
    ill_d       = ill_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          sel_d   = sel;
          cout_d  = 1'b0;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
          state_d = is_iterative(sel) ? CALC : EXEC;
        end
      end
      EXEC: begin
        out1_d  = exec_out1;
        out2_d  = exec_out2;
        cout_d  = exec_cout;
        ill_d   = exec_ill;
        dz_d    = 1'b0;
        zero_d  = (exec_out1 == '0);
        state_d = DONE;
      end
      CALC: begin
        if (md_done) begin
          out1_d  = md_lo;
          out2_d  = md_hi;
          cout_d  = 1'b0;
          ill_d   = 1'b0;
          dz_d    = (sel_q == OP_DIV) && (b_q == '0);
          zero_d  = (md_lo == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register update with synchronous reset to an idle, all-zero state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sel_q       <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      sel_q       <= sel_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      dz_q        <= dz_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign dz        = dz_q;
  assign ill       = ill_q;

endmodule
